lsu_ram_master: RTL and testbench

Load/store initiator that drives the data-side read/write port of the 128 KiB dual-port program/data RAM. It accepts one RV32 load or store at a time from the core's execute stage and converts it into 64-bit word accesses with byte write enables, splitting misaligned accesses that cross an 8-byte boundary into two beats. It also aligns and sign/zero-extends load data and returns one response per request.

---
 rtl/lsu_ram_master.sv | 192 +++++++++++++++++++
 tb/tb_lsu_ram_master.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ram_master.sv
// lsu_ram_master
//   Load/store initiator for the data-side port of the 64-bit-wide program/data
//   RAM. Takes one RV32 load/store at a time and turns it into one or two 64-bit
//   word beats with byte enables. Loads are aligned and sign/zero-extended.
//   Exactly one response is returned per accepted request.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   req_valid/req_ready   request handshake (ready only while idle)
//   req_we, req_funct3    store flag, RV32 funct3 (B/H/W/BU/HU)
//   req_addr, req_wdata   byte address, right-justified store data
//   rsp_valid/rsp_ready   response handshake (response held until taken)
//   rsp_rdata, rsp_err    extended load data, illegal/disallowed-crossing flag
//   enb, renb, web        RAM enable, load-beat flag, byte write enables
//   addrb, dinb, doutb    RAM word address, write data, read data (1-cycle latency)
module lsu_ram_master #(
  parameter int ADDR_W   = 14,
  parameter bit SPLIT_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_funct3,
  input  logic [31:0]       req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err,
  output logic              enb,
  output logic              renb,
  output logic [7:0]        web,
  output logic [ADDR_W-1:0] addrb,
  output logic [63:0]       dinb,
  input  logic [63:0]       doutb
);

  typedef enum logic [2:0] {S_IDLE, S_ACC0, S_ACC1, S_FIN, S_RESP} state_t;

  state_t              r_state, w_next;
  logic                r_we, r_cross, r_err;
  logic [2:0]          r_f3, r_off;
  logic [3:0]          r_size;
  logic [ADDR_W-1:0]   r_word;
  logic [31:0]         r_wdata, r_rdata;
  logic [63:0]         r_beat0;

  // Request decode, evaluated on the incoming fields so the accept edge can
  // already route illegal requests straight to RESP.
  logic                w_accept, w_req_cross, w_req_illegal;
  logic [3:0]          w_req_size;

  assign w_accept = req_valid && (r_state == S_IDLE);

  always_comb begin
    w_req_size = 4'd4;
    case (req_funct3[1:0])
      2'b00:   w_req_size = 4'd1;
      2'b01:   w_req_size = 4'd2;
      default: w_req_size = 4'd4;
    endcase
  end

  assign w_req_cross   = ({1'b0, req_addr[2:0]} + w_req_size) > 4'd8;
  assign w_req_illegal = (req_funct3 == 3'b011) || (req_funct3 == 3'b110) ||
                         (req_funct3 == 3'b111) || (req_we && req_funct3[2]) ||
                         (w_req_cross && !SPLIT_EN);

  // Store lanes: a 16-byte window spanning the addressed word and the next one.
  logic [15:0]  w_size_mask, w_mask16;
  logic [31:0]  w_wdata_m;
  logic [127:0] w_data128;

  assign w_size_mask = (16'd1 << r_size) - 16'd1;
  assign w_mask16    = w_size_mask << r_off;

  always_comb begin
    w_wdata_m = r_wdata;
    case (r_size)
      4'd1:    w_wdata_m = {24'd0, r_wdata[7:0]};
      4'd2:    w_wdata_m = {16'd0, r_wdata[15:0]};
      default: w_wdata_m = r_wdata;
    endcase
  end

  assign w_data128 = {96'd0, w_wdata_m} << {r_off, 3'b000};

  // Load assembly. For a crossing load beat 0 was parked in r_beat0 during
  // ACC1 and doutb now carries beat 1; otherwise doutb is the only beat.
  logic [63:0]  w_b0, w_b1;
  logic [127:0] w_cat;
  logic [31:0]  w_ld_data;

  assign w_b0  = r_cross ? r_beat0 : doutb;
  assign w_b1  = r_cross ? doutb   : 64'd0;
  assign w_cat = {w_b1, w_b0} >> {r_off, 3'b000};

  always_comb begin
    w_ld_data = w_cat[31:0];
    case (r_f3)
      3'b000:  w_ld_data = {{24{w_cat[7]}},  w_cat[7:0]};
      3'b001:  w_ld_data = {{16{w_cat[15]}}, w_cat[15:0]};
      3'b100:  w_ld_data = {24'd0, w_cat[7:0]};
      3'b101:  w_ld_data = {16'd0, w_cat[15:0]};
      default: w_ld_data = w_cat[31:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_we    <= 1'b0;
      r_f3    <= 3'd0;
      r_off   <= 3'd0;
      r_size  <= 4'd0;
      r_cross <= 1'b0;
      r_word  <= '0;
      r_wdata <= 32'd0;
      r_beat0 <= 64'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept) begin
        r_we    <= req_we;
        r_f3    <= req_funct3;
        r_off   <= req_addr[2:0];
        r_size  <= w_req_size;
        r_cross <= w_req_cross;
        r_word  <= req_addr[ADDR_W+2:3];
        r_wdata <= req_wdata;
        r_rdata <= 32'd0;
        r_err   <= w_req_illegal;
      end
      if (r_state == S_ACC1) r_beat0 <= doutb;
      if (r_state == S_FIN)  r_rdata <= r_we ? 32'd0 : w_ld_data;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = w_req_illegal ? S_RESP : S_ACC0;
      S_ACC0:  w_next = r_cross ? S_ACC1 : S_FIN;
      S_ACC1:  w_next = S_FIN;
      S_FIN:   w_next = S_RESP;
      S_RESP:  if (rsp_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // RAM port is driven straight from the state so a beat lands in RAM on the
  // same edge that a reset may be sampled; nothing after that edge is issued.
  always_comb begin
    enb   = 1'b0;
    renb  = 1'b0;
    web   = 8'd0;
    dinb  = 64'd0;
    addrb = r_word;
    case (r_state)
      S_ACC0: begin
        enb  = 1'b1;
        renb = !r_we;
        if (r_we) begin
          web  = w_mask16[7:0];
          dinb = w_data128[63:0];
        end
      end
      S_ACC1: begin
        enb   = 1'b1;
        renb  = !r_we;
        addrb = r_word + ADDR_W'(1);
        if (r_we) begin
          web  = w_mask16[15:8];
          dinb = w_data128[127:64];
        end
      end
      default: ;
    endcase
  end

  assign req_ready = (r_state == S_IDLE);
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

  logic w_unused;
  assign w_unused = &{1'b0, req_addr[31:ADDR_W+3], w_cat[127:32]};

endmodule

// File: tb/tb_lsu_ram_master.sv
module tb_lsu_ram_master;
  localparam int ADDR_W = 14;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst, req_valid, req_ready, req_we, rsp_valid, rsp_ready, rsp_err;
  logic              enb, renb;
  logic [2:0]        req_funct3;
  logic [31:0]       req_addr, req_wdata, rsp_rdata;
  logic [7:0]        web;
  logic [ADDR_W-1:0] addrb;
  logic [63:0]       dinb, doutb;

  lsu_ram_master #(.ADDR_W(ADDR_W), .SPLIT_EN(1'b1)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .enb(enb), .renb(renb),
    .web(web), .addrb(addrb), .dinb(dinb), .doutb(doutb)
  );

  // Second instance with splitting disabled; its RAM port reads zeros.
  logic              ns_req_valid, ns_req_ready, ns_req_we, ns_rsp_valid, ns_rsp_ready, ns_rsp_err;
  logic              ns_enb, ns_renb;
  logic [2:0]        ns_req_funct3;
  logic [31:0]       ns_req_addr, ns_req_wdata, ns_rsp_rdata;
  logic [7:0]        ns_web;
  logic [ADDR_W-1:0] ns_addrb;
  logic [63:0]       ns_dinb;
  logic [63:0]       ns_doutb = 64'd0;
  int                ns_enb_cnt = 0;

  lsu_ram_master #(.ADDR_W(ADDR_W), .SPLIT_EN(1'b0)) u_ns (
    .clk(clk), .rst(rst), .req_valid(ns_req_valid), .req_ready(ns_req_ready),
    .req_we(ns_req_we), .req_funct3(ns_req_funct3), .req_addr(ns_req_addr),
    .req_wdata(ns_req_wdata), .rsp_valid(ns_rsp_valid), .rsp_ready(ns_rsp_ready),
    .rsp_rdata(ns_rsp_rdata), .rsp_err(ns_rsp_err), .enb(ns_enb), .renb(ns_renb),
    .web(ns_web), .addrb(ns_addrb), .dinb(ns_dinb), .doutb(ns_doutb)
  );

  always @(posedge clk) if (ns_enb) ns_enb_cnt <= ns_enb_cnt + 1;

  // RAM model: synchronous, byte-writable, read data one cycle after enb.
  logic [63:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (enb) begin
      for (int b = 0; b < 8; b++)
        if (web[b]) mem[addrb][8*b +: 8] <= dinb[8*b +: 8];
      doutb <= mem[addrb];
    end
  end

  typedef struct packed {
    logic [ADDR_W-1:0] a;
    logic [7:0]        we;
    logic [63:0]       d;
    logic              rd;
  } beat_t;
  beat_t beats[$];
  always @(posedge clk) if (enb) beats.push_back('{addrb, web, dinb, renb});

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
  } exp_t;
  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=0x%0h exp=0x%0h", nm, act, exp);
    end
  endtask

  // Monitor: pops one expectation per new response, checks latency from the
  // accept cycle, and re-checks the held values every cycle of backpressure.
  int   acc_cyc = 0;
  bit   held = 1'b0;
  exp_t cur;
  always @(negedge clk) begin
    if (rst) held = 1'b0;
    else begin
      if (req_valid && req_ready) acc_cyc = cyc;
      if (rsp_valid) begin
        if (!held) begin
          if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_rsp act=rsp_valid exp=no_response");
          end else begin
            cur = sb.pop_front();
            chk("rsp_rdata", rsp_rdata, cur.rdata);
            chk("rsp_err", rsp_err, cur.err);
            chk("rsp_latency", cyc - acc_cyc, cur.lat);
          end
        end else begin
          chk("hold_rdata", rsp_rdata, cur.rdata);
          chk("hold_err", rsp_err, cur.err);
        end
        held = !rsp_ready;
      end else begin
        if (held) chk("hold_valid", rsp_valid, 1);
        held = 1'b0;
      end
    end
  end

  task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] er, input logic ee,
                        input int lat, input int hold);
    int n;
    sb.push_back('{er, ee, lat});
    beats.delete();
    rsp_ready  = (hold == 0);
    req_valid  = 1'b1;
    req_we     = we;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    if (!req_ready) chk("accept_timeout", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!rsp_valid && n < 20);
    if (!rsp_valid) chk("rsp_timeout", rsp_valid, 1);
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        @(negedge clk);
        chk("bp_req_ready", req_ready, 0);
        chk("bp_rsp_valid", rsp_valid, 1);
      end
      @(posedge clk); #1;
      rsp_ready = 1'b1;
      @(negedge clk);
    end
    @(posedge clk); #1;
  endtask

  task automatic chk_beat(input int i, input logic [ADDR_W-1:0] a, input logic [7:0] w,
                          input logic [63:0] d, input logic rd);
    beat_t e;
    e = '{a, w, d, rd};
    if (i < beats.size()) chk($sformatf("beat%0d", i), beats[i], e);
    else chk($sformatf("beat%0d_missing", i), beats.size(), i + 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 64'd0;
    mem[0] = 64'h0706050403020100;
    mem[1] = 64'h0000000000008000;
    mem[2] = 64'h1122334455667788;
    doutb = 64'd0;
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
    req_addr = 32'd0; req_wdata = 32'd0; rsp_ready = 1'b1;
    ns_req_valid = 1'b0; ns_req_we = 1'b0; ns_req_funct3 = 3'd0;
    ns_req_addr = 32'd0; ns_req_wdata = 32'd0; ns_rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_req_ready", req_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_rdata", rsp_rdata, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_ram_port", {enb, renb, web, addrb, dinb}, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Loads: aligned word, bytes and halfwords with sign/zero extension.
    do_req(0, 3'b010, 32'h10, 0, 32'h55667788, 0, 3, 0);
    chk("lw_nbeats", beats.size(), 1);
    chk_beat(0, 14'h2, 8'h00, 64'd0, 1'b1);
    do_req(0, 3'b000, 32'h17, 0, 32'h00000011, 0, 3, 0);
    do_req(0, 3'b000, 32'h09, 0, 32'hFFFFFF80, 0, 3, 0);
    do_req(0, 3'b100, 32'h09, 0, 32'h00000080, 0, 3, 0);
    do_req(0, 3'b101, 32'h16, 0, 32'h00001122, 0, 3, 0);
    do_req(0, 3'b001, 32'h08, 0, 32'hFFFF8000, 0, 3, 0);
    do_req(0, 3'b101, 32'h08, 0, 32'h00008000, 0, 3, 0);
    // Crossing loads: halfword at offset 7, word at offset 5.
    do_req(0, 3'b001, 32'h0F, 0, 32'hFFFF8800, 0, 4, 0);
    do_req(0, 3'b010, 32'h15, 0, 32'h00112233, 0, 4, 0);

    // Halfword store into the middle of word 0, then read it back.
    do_req(1, 3'b001, 32'h03, 32'hDEADBEEF, 32'd0, 0, 3, 0);
    chk("sh_nbeats", beats.size(), 1);
    chk_beat(0, 14'h0, 8'h18, 64'h000000BEEF000000, 1'b0);
    do_req(0, 3'b010, 32'h00, 0, 32'hEF020100, 0, 3, 0);

    // Split store wrapping from the last word to word 0, then read back.
    do_req(1, 3'b010, 32'h1FFFE, 32'hA1B2C3D4, 32'd0, 0, 4, 0);
    chk("ssw_nbeats", beats.size(), 2);
    chk_beat(0, 14'h3FFF, 8'hC0, 64'hC3D4000000000000, 1'b0);
    chk_beat(1, 14'h0000, 8'h03, 64'h000000000000A1B2, 1'b0);
    do_req(0, 3'b010, 32'h1FFFE, 0, 32'hA1B2C3D4, 0, 4, 0);
    chk("slw_nbeats", beats.size(), 2);
    chk_beat(0, 14'h3FFF, 8'h00, 64'd0, 1'b1);
    chk_beat(1, 14'h0000, 8'h00, 64'd0, 1'b1);

    // Illegal requests: no RAM access, immediate error response.
    do_req(0, 3'b011, 32'h10, 0, 32'd0, 1, 1, 0);
    chk("ill_ld_nbeats", beats.size(), 0);
    do_req(1, 3'b100, 32'h10, 32'hFF, 32'd0, 1, 1, 0);
    chk("ill_st_nbeats", beats.size(), 0);

    // Backpressure: response held stable while rsp_ready is low.
    do_req(0, 3'b010, 32'h10, 0, 32'h55667788, 0, 3, 5);

    // Reset during ACC0 of a split store: only beat 0 reaches RAM.
    beats.delete();
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b010;
    req_addr = 32'h1FFFE; req_wdata = 32'h11223344;
    @(negedge clk);
    chk("rst_test_accept", req_ready, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("rst_test_acc0_enb", enb, 1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_test_rsp_valid", rsp_valid, 0);
    chk("rst_test_req_ready", req_ready, 1);
    chk("rst_test_enb", enb, 0);
    @(posedge clk); #1;
    chk("rst_test_nbeats", beats.size(), 1);
    chk_beat(0, 14'h3FFF, 8'hC0, 64'h3344000000000000, 1'b0);
    do_req(0, 3'b010, 32'h1FFFE, 0, 32'hA1B23344, 0, 4, 0);

    // SPLIT_EN=0: a crossing word load is rejected without touching RAM.
    ns_req_valid = 1'b1; ns_req_we = 1'b0; ns_req_funct3 = 3'b010; ns_req_addr = 32'h15;
    @(negedge clk);
    chk("ns_req_ready", ns_req_ready, 1);
    @(posedge clk); #1;
    ns_req_valid = 1'b0;
    @(negedge clk);
    chk("ns_rsp_valid_t1", ns_rsp_valid, 1);
    chk("ns_rsp_err", ns_rsp_err, 1);
    chk("ns_rsp_rdata", ns_rsp_rdata, 0);
    @(posedge clk); #1;
    n = ns_enb_cnt;
    chk("ns_enb_count", n, 0);

    repeat (2) @(posedge clk);
    chk("sb_empty", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
